mem_access_ctrl: RTL and testbench

Multi-cycle memory access controller between the instruction/data address mux (IorD) and the 256-byte unified memory. It takes a byte address plus an access size and direction from the control unit and sequences word, halfword and byte loads and stores against a word-wide memory with fixed read latency. Sub-word stores use read-modify-write. Misaligned requests are rejected with an error pulse and make no memory access. Exception-vector bytes at 253/254/255 are fetched as plain byte reads.

---
 rtl/mem_access_pkg.sv | 16 +
 rtl/mem_access_ctrl_lane_unit.sv | 18 +
 rtl/mem_access_ctrl.sv | 93 +++++++++
 tb/tb_mem_access_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the memory access controller and its clients
package mem_access_pkg;
    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_e;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_STORE = 1'b1;
    localparam logic [31:0] EXC_VEC_0 = 32'd253;
    localparam logic [31:0] EXC_VEC_1 = 32'd254;
    localparam logic [31:0] EXC_VEC_2 = 32'd255;
    // size 11 has no valid encoding, so it is always rejected
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return size == SZ_WORD ? |lo : size == SZ_HALF ? lo[0] : size != SZ_BYTE;
    endfunction
endpackage

// File: rtl/mem_access_ctrl_lane_unit.sv
// lane_unit: extracts a zero-extended load lane and merges a sub-word store into a word
module lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rd_val,
    output logic [31:0] wr_word
);
    logic [4:0]  amt;
    logic [31:0] mask;
    assign amt = {addr_lo, 3'b000};
    assign mask = size == SZ_WORD ? 32'hFFFF_FFFF : size == SZ_HALF ? 32'h0000_FFFF : 32'h0000_00FF;
    assign rd_val = (word >> amt) & mask;
    assign wr_word = (word & ~(mask << amt)) | ((wdata & mask) << amt);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences word/halfword/byte loads and stores against a fixed-latency word memory
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   addr_q, wdata_q, rdata_q, mem_wdata_q;
    logic [1:0]    size_q;
    logic          op_q, mem_we_q;
    logic [31:0]   ld_val, st_word;

    lane_unit u_lane (
        .word    (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .size    (size_q),
        .wdata   (wdata_q),
        .rd_val  (ld_val),
        .wr_word (st_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            op_q        <= 1'b0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    addr_q  <= addr;
                    op_q    <= op;
                    size_q  <= size;
                    wdata_q <= wdata;
                    cnt_q   <= CW'(MEM_LAT - 1);
                    if (misaligned(size, addr[1:0])) state_q <= ERR;
                    else if (op == OP_STORE && size == SZ_WORD) begin
                        state_q     <= WR;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= wdata;
                    end else state_q <= RD;
                end
                // sub-word stores fall through to WR with the merged word
                RD: if (cnt_q == '0) begin
                    if (op_q == OP_LOAD) begin
                        rdata_q <= ld_val;
                        state_q <= DONE;
                    end else begin
                        mem_wdata_q <= st_word;
                        mem_we_q    <= 1'b1;
                        state_q     <= WR;
                    end
                end else cnt_q <= cnt_q - 1'b1;
                WR:      state_q <= DONE;
                DONE:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE || state_q == ERR;
    assign err = state_q == ERR;
    assign rdata = rdata_q;
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign mem_we = mem_we_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: runs MEM_LAT=1 and MEM_LAT=2 controllers in lockstep against a byte-level memory model
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic [1:0] rst_n;
    logic start, op;
    logic [1:0] size;
    logic [31:0] addr, wdata;
    logic [1:0] busy, done, err, mem_we;
    logic [1:0][31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    int checks = 0, failures = 0;
    logic [7:0] ref_b [256];
    logic [31:0] ref_rdata [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i + 1) * 32'h9E37_79B9;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [64];
        logic [31:0] pipe;
        initial for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        always @(posedge clk) begin
            pipe <= mem[mem_addr[g][7:2]];
            if (mem_we[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
        end
        assign mem_rdata[g] = g == 0 ? mem[mem_addr[g][7:2]] : pipe;
        mem_access_ctrl #(.MEM_LAT(g + 1)) dut (
            .clk(clk), .reset_n(rst_n[g]), .start(start), .op(op), .size(size),
            .addr(addr), .wdata(wdata), .busy(busy[g]), .done(done[g]), .err(err[g]),
            .rdata(rdata[g]), .mem_addr(mem_addr[g]), .mem_we(mem_we[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb);
        logic [31:0] r = '0;
        for (int j = 0; j < nb; j++) r |= 32'(ref_b[int'(a[7:0]) + j]) << (8 * j);
        return r;
    endfunction

    task automatic do_op(input logic o, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int hold);
        int nb, dmax;
        int d [2];
        int wr [2];
        logic bad, ld, st;
        logic [31:0] nv, wexp, al, rexp;
        nb = sz == 2'd0 ? 4 : sz == 2'd1 ? 2 : 1;
        bad = sz == 2'd3 || (a % nb) != 0;
        ld = !bad && !o;
        st = !bad && o;
        al = a & ~32'd3;
        nv = ld ? ref_load(a, nb) : '0;
        wexp = '0;
        if (st) begin
            for (int j = 0; j < nb; j++) ref_b[int'(a[7:0]) + j] = wd[8*j +: 8];
            wexp = ref_load(al, 4);
        end
        for (int g = 0; g < 2; g++) begin
            d[g] = bad ? 1 : ld ? g + 2 : (sz == 2'd0 ? 2 : g + 3);
            wr[g] = st ? (sz == 2'd0 ? 1 : g + 2) : -1;
        end
        dmax = d[1];
        op = o; size = sz; addr = a; wdata = wd; start = 1'b1;
        for (int k = 1; k <= dmax + 1; k++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check($sformatf("busy%0d_k%0d", g, k), 32'(busy[g]), 32'(k <= d[g]));
                check($sformatf("done%0d_k%0d", g, k), 32'(done[g]), 32'(k == d[g]));
                check($sformatf("err%0d_k%0d", g, k), 32'(err[g]), 32'(k == d[g] && bad));
                check($sformatf("we%0d_k%0d", g, k), 32'(mem_we[g]), 32'(k == wr[g]));
                if (k == wr[g]) check($sformatf("wdata%0d", g), mem_wdata[g], wexp);
                if (k == d[g]) check($sformatf("maddr%0d", g), mem_addr[g], al);
                rexp = (ld && k >= d[g]) ? nv : ref_rdata[g];
                check($sformatf("rdata%0d_k%0d", g, k), rdata[g], rexp);
            end
            if (k >= hold) start = 1'b0;
        end
        if (ld) begin
            ref_rdata[0] = nv;
            ref_rdata[1] = nv;
        end
    endtask

    task automatic rst_test(input logic [31:0] a, input logic [31:0] wd);
        op = 1'b1; size = 2'd2; addr = a; wdata = wd; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            for (int g = 0; g < 2; g++) begin
                if (k == g + 2) begin
                    check($sformatf("rst_we_pre%0d", g), 32'(mem_we[g]), 32'd1);
                    rst_n[g] = 1'b0;
                    #1;
                    check($sformatf("rst_we%0d", g), 32'(mem_we[g]), 32'd0);
                    check($sformatf("rst_busy%0d", g), 32'(busy[g]), 32'd0);
                    check($sformatf("rst_done%0d", g), 32'(done[g]), 32'd0);
                    check($sformatf("rst_rdata%0d", g), rdata[g], 32'd0);
                    ref_rdata[g] = '0;
                end else if (k == g + 3) rst_n[g] = 1'b1;
            end
        end
        for (int g = 0; g < 2; g++) check($sformatf("rst_idle%0d", g), 32'(busy[g]), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 2'b00; start = 1'b0; op = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        for (int i = 0; i < 64; i++) begin
            w = init_word(i);
            for (int j = 0; j < 4; j++) ref_b[4*i + j] = w[8*j +: 8];
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset_busy%0d", g), 32'(busy[g]), 32'd0);
            check($sformatf("reset_done%0d", g), 32'(done[g]), 32'd0);
            check($sformatf("reset_err%0d", g), 32'(err[g]), 32'd0);
            check($sformatf("reset_we%0d", g), 32'(mem_we[g]), 32'd0);
            check($sformatf("reset_rdata%0d", g), rdata[g], 32'd0);
            check($sformatf("reset_wdata%0d", g), mem_wdata[g], 32'd0);
            check($sformatf("reset_maddr%0d", g), mem_addr[g], 32'd0);
        end
        rst_n = 2'b11;
        do_op(1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 1);
        do_op(1'b0, 2'd0, 32'h10, 32'h0, 1);
        check("tp_word0", rdata[0], 32'hDEADBEEF);
        check("tp_word1", rdata[1], 32'hDEADBEEF);
        do_op(1'b1, 2'd0, 32'd252, 32'h44332211, 1);
        do_op(1'b0, 2'd2, 32'd254, 32'h0, 1);
        check("tp_vec254", rdata[0], 32'h33);
        do_op(1'b0, 2'd2, 32'd253, 32'h0, 1);
        do_op(1'b0, 2'd2, 32'd255, 32'h0, 1);
        check("tp_vec255", rdata[1], 32'h44);
        do_op(1'b1, 2'd0, 32'h10, 32'hCAFEBABE, 1);
        do_op(1'b0, 2'd1, 32'h12, 32'h0, 1);
        check("tp_half", rdata[0], 32'h0000CAFE);
        do_op(1'b1, 2'd0, 32'h20, 32'h11223344, 1);
        do_op(1'b1, 2'd2, 32'h21, 32'hFFFFFFAB, 1);
        check("tp_bst_rdata", rdata[1], 32'h0000CAFE);
        do_op(1'b0, 2'd0, 32'h20, 32'h0, 1);
        check("tp_bst_word", rdata[0], 32'h1122AB44);
        do_op(1'b0, 2'd0, 32'h02, 32'h0, 1);
        do_op(1'b1, 2'd1, 32'h05, 32'h12345678, 1);
        do_op(1'b0, 2'd3, 32'h08, 32'h0, 1);
        check("tp_err_rdata", rdata[0], 32'h1122AB44);
        do_op(1'b0, 2'd0, 32'h40, 32'h0, 2);
        do_op(1'b0, 2'd1, 32'h46, 32'h0, 1);
        rst_test(32'h31, 32'h000000EE);
        do_op(1'b0, 2'd0, 32'h30, 32'h0, 1);
        check("rst_mem_kept", rdata[0], init_word(12));
        for (int n = 0; n < 60; n++)
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  32'($urandom_range(0, 255)), $urandom, $urandom_range(1, 2));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
